// File: rtl/frame_overlap_discard.sv
// Overlap-discard stage: rebuilds a continuous sample stream from overlapping FFT frames.
// Optional FRAME_LAST_OUT_EN adds m_last, flagging the last kept sample of each terminated frame.
`timescale 1ns/1ps
module frame_overlap_discard #(
  parameter int DATA_W     = 16,
  parameter int FFT_POINT  = 256,
  parameter int OVERLAP    = 52,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
`ifdef FRAME_LAST_OUT_EN
  output logic              m_last,
`endif
  output logic              frame_err,
  output logic [15:0]       frame_cnt
);

  localparam int IDX_W = $clog2(FFT_POINT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef FRAME_LAST_OUT_EN
  localparam int FW = DATA_W + 1;
`else
  localparam int FW = DATA_W;
`endif
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(FFT_POINT - 1);
  localparam logic [IDX_W-1:0] OVL     = IDX_W'(OVERLAP);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FIRST, FRAME, RESYNC} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [15:0]      frame_cnt_q;
  logic             frame_err_q;

  logic [FW-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             fifo_full, fifo_empty;
  logic             acc, keep, push, pop;
  logic [FW-1:0]    wr_word, head;

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);

  // Backpressure looks at full only, so a simultaneous pop never frees a slot for a push.
  assign s_ready = (state_q != IDLE) && !fifo_full;
  assign acc     = s_valid && s_ready;

  always_comb begin
    keep = 1'b0;
    case (state_q)
      FIRST:   keep = 1'b1;
      FRAME:   keep = (idx_q >= OVL);
      default: keep = 1'b0;
    endcase
  end

  assign push = acc && keep;
  assign pop  = m_valid && m_ready;

`ifdef FRAME_LAST_OUT_EN
  assign wr_word = {s_last, s_data};
`else
  assign wr_word = s_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) state_q <= FIRST;
        end
        FIRST, FRAME: begin
          if (acc) begin
            if (s_last) begin
              idx_q   <= '0;
              state_q <= FRAME;
              if (idx_q == IDX_MAX) frame_cnt_q <= frame_cnt_q + 16'd1;
              else                  frame_err_q <= 1'b1;
            end else if (idx_q == IDX_MAX) begin
              idx_q       <= '0;
              frame_err_q <= 1'b1;
              state_q     <= RESYNC;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        RESYNC: begin
          if (acc) begin
            if (s_last) begin
              idx_q   <= '0;
              state_q <= FRAME;
            end else if (idx_q == IDX_MAX) begin
              idx_q <= '0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // First-word-fall-through storage; the head entry drives the output directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_word;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign m_data    = head[DATA_W-1:0];
  assign m_valid   = !fifo_empty;
`ifdef FRAME_LAST_OUT_EN
  assign m_last    = head[DATA_W];
`endif
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule
